// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the CPU load/store port.
// Takes one word request at a time over a valid/ready handshake, waits a fixed
// latency, then presents the response (load data or store ack) until consumed.
// Optional feature: define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range
// requests; when undefined the low address bits are ignored and the word index
// wraps modulo DEPTH.
module dmem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } stateT;

    stateT             state;
    logic [3:0]        count;
    logic              capWrite;
    logic [31:0]       capAddr;
    logic [31:0]       capWdata;
    logic [31:0]       rdataQ;
    logic [31:0]       mem [DEPTH];

    logic              reqFire;
    logic              doAccess;
    logic              accWrite;
    logic [31:0]       accAddr;
    logic [31:0]       accWdata;
    logic [IDX_W-1:0]  accIdx;
    logic              accErr;
    logic              memWe;

    assign reqFire = (state == IDLE) && req_valid_i;

    // The memory access happens on the edge that enters RESP. With LATENCY=1
    // that is the accept edge itself, so the operands come straight from the
    // request inputs instead of the capture registers.
    always_comb begin
        doAccess = 1'b0;
        accWrite = capWrite;
        accAddr  = capAddr;
        accWdata = capWdata;
        if (LATENCY == 1) begin
            doAccess = reqFire;
            accWrite = req_write_i;
            accAddr  = req_addr_i;
            accWdata = req_wdata_i;
        end else begin
            doAccess = (state == WAIT) && (count == 4'd1);
        end
    end

    assign accIdx = accAddr[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
    // Misaligned, or word index beyond DEPTH (DEPTH is a power of two, so any
    // set bit above the index field means out of range).
    assign accErr = (accAddr[1:0] != 2'b00) || (accAddr[31:IDX_W+2] != '0);
`else
    logic unusedAddrBits;
    assign accErr         = 1'b0;
    assign unusedAddrBits = ^{accAddr[1:0], accAddr[31:IDX_W+2]};
`endif

    assign memWe = doAccess && accWrite && !accErr;

    // Word storage; cleared on reset, written only by a non-erroring store.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (memWe) begin
            mem[accIdx] <= accWdata;
        end
    end

    // Request/response FSM with latency counter and registered load data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            count    <= '0;
            capWrite <= 1'b0;
            capAddr  <= '0;
            capWdata <= '0;
            rdataQ   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        capWrite <= req_write_i;
                        capAddr  <= req_addr_i;
                        capWdata <= req_wdata_i;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (doAccess) begin
                rdataQ <= (accWrite || accErr) ? '0 : mem[accIdx];
            end
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    logic errQ;

    // Error flag captured alongside the response data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            errQ <= 1'b0;
        end else if (doAccess) begin
            errQ <= accErr;
        end
    end

    assign resp_err_o = errQ;
`else
    assign resp_err_o = 1'b0;
`endif

    // Ready is held low for the whole time reset is asserted.
    assign req_ready_o  = rst_i && (state == IDLE);
    assign resp_valid_o = (state == RESP);
    assign resp_rdata_o = rdataQ;
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: bench-side memory model feeds an
// expected-response queue, popped when the DUT presents each response.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 128;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        respValid;
    logic        respReady;
    logic [31:0] respRdata;
    logic        respErr;
    logic        busy;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } expT;

    expT         expQ[$];
    logic [31:0] model [DEPTH];
    int          cycle = 0;
    int          nCompared = 0;
    int          nMismatched = 0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i        (clk),
        .rst_i        (rstN),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_write_i  (reqWrite),
        .req_addr_i   (reqAddr),
        .req_wdata_i  (reqWdata),
        .resp_valid_o (respValid),
        .resp_ready_i (respReady),
        .resp_rdata_o (respRdata),
        .resp_err_o   (respErr),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Bench memory model: computes the expected response and updates itself.
    function automatic void pushExp(input logic w, input logic [31:0] a, input logic [31:0] d);
        expT e;
        logic err;
        int unsigned idx;
`ifdef DMEM_ERR_CHECK_EN
        err = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
`else
        err = 1'b0;
`endif
        idx = (a >> 2) % DEPTH;
        e.err = err;
        e.rdata = '0;
        if (!err) begin
            if (w) model[idx] = d;
            else   e.rdata = model[idx];
        end
        expQ.push_back(e);
    endfunction

    // Present a request and hold it until the handshake edge; acceptCycle is
    // the cycle in which valid and ready were both seen.
    task automatic sendReq(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int acceptCycle, output bit ok);
        ok = 1'b0;
        acceptCycle = -1;
        reqValid = 1'b1;
        reqWrite = w;
        reqAddr  = a;
        reqWdata = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (reqReady) begin
                acceptCycle = cycle;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqWrite = $urandom_range(0, 1);
        reqAddr  = $urandom;
        reqWdata = $urandom;
    endtask

    task automatic waitResp(output logic [31:0] rd, output logic er, output int rc, output bit ok);
        ok = 1'b0;
        rd = '0;
        er = 1'b0;
        rc = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (respValid) begin
                rd = respRdata;
                er = respErr;
                rc = cycle;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int  acc;
        bit  ok;
        int  rc;
        logic [31:0] rd;
        logic er;
        expT e;
        rstN = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
        respReady = 1'b1;
        repeat (3) @(negedge clk);
        nCompared++;
        if ({reqReady, respValid, busy, respErr, respRdata} !== 36'h0) begin
            nMismatched++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b err=%b rdata=%h, expected all 0",
                     reqReady, respValid, busy, respErr, respRdata);
        end
        rstN = 1'b1;
        #1;
        nCompared++;
        if (reqReady !== 1'b1 || busy !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_release: got rdy=%b busy=%b, expected rdy=1 busy=0", reqReady, busy);
        end
        // Store to 0x10 accepted, then reset while it is still waiting.
        sendReq(1'b1, 32'h10, 32'hCAFE_F00D, acc, ok);
        nCompared++;
        if (!ok || busy !== 1'b1) begin
            nMismatched++;
            $display("FAIL midwait_busy: got accepted=%b busy=%b, expected 1 1", ok, busy);
        end
        rstN = 1'b0;
        #1;
        nCompared++;
        if (busy !== 1'b0 || respValid !== 1'b0 || reqReady !== 1'b0) begin
            nMismatched++;
            $display("FAIL midwait_reset: got busy=%b vld=%b rdy=%b, expected 0 0 0", busy, respValid, reqReady);
        end
        @(negedge clk);
        rstN = 1'b1;
        foreach (model[i]) model[i] = '0;
        expQ.delete();
        pushExp(1'b0, 32'h10, '0);
        sendReq(1'b0, 32'h10, '0, acc, ok);
        waitResp(rd, er, rc, ok);
        e = expQ.pop_front();
        nCompared++;
        if (!ok || rd !== e.rdata || er !== e.err) begin
            nMismatched++;
            $display("FAIL reset_load: got ok=%b rdata=%h err=%b, expected rdata=%h err=%b", ok, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_store_load;
        int  acc;
        int  rc;
        bit  ok;
        logic [31:0] rd;
        logic er;
        expT e;
        respReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic w;
            w = (k == 0);
            pushExp(w, 32'h40, 32'hDEAD_BEEF);
            sendReq(w, 32'h40, 32'hDEAD_BEEF, acc, ok);
            waitResp(rd, er, rc, ok);
            e = expQ.pop_front();
            nCompared++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                nMismatched++;
                $display("FAIL store_load_%0d: got ok=%b rdata=%h err=%b, expected rdata=%h err=%b",
                         k, ok, rd, er, e.rdata, e.err);
            end
            nCompared++;
            if (rc - acc != int'(LATENCY)) begin
                nMismatched++;
                $display("FAIL latency_%0d: got %0d cycles, expected %0d", k, rc - acc, LATENCY);
            end
            @(negedge clk);
            nCompared++;
            if (respValid !== 1'b0 || reqReady !== 1'b1) begin
                nMismatched++;
                $display("FAIL one_cycle_resp_%0d: got vld=%b rdy=%b, expected vld=0 rdy=1", k, respValid, reqReady);
            end
        end
    endtask

    task automatic test_backpressure;
        int  acc;
        int  rc;
        bit  ok;
        logic [31:0] rd;
        logic er;
        expT e;
        respReady = 1'b0;
        pushExp(1'b0, 32'h40, '0);
        sendReq(1'b0, 32'h40, '0, acc, ok);
        waitResp(rd, er, rc, ok);
        e = expQ.pop_front();
        nCompared++;
        if (!ok || rd !== e.rdata || er !== e.err) begin
            nMismatched++;
            $display("FAIL stall_resp: got ok=%b rdata=%h err=%b, expected rdata=%h err=%b", ok, rd, er, e.rdata, e.err);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nCompared++;
            if (respValid !== 1'b1 || respRdata !== e.rdata || reqReady !== 1'b0) begin
                nMismatched++;
                $display("FAIL stall_hold_%0d: got vld=%b rdata=%h rdy=%b, expected vld=1 rdata=%h rdy=0",
                         i, respValid, respRdata, reqReady, e.rdata);
            end
        end
        respReady = 1'b1;
        @(posedge clk);
        #1;
        nCompared++;
        if (respValid !== 1'b0 || reqReady !== 1'b1) begin
            nMismatched++;
            $display("FAIL stall_release: got vld=%b rdy=%b, expected vld=0 rdy=1", respValid, reqReady);
        end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [4];
        logic        writes [4];
        int  acc;
        int  rc;
        bit  ok;
        logic [31:0] rd;
        logic er;
        expT e;
        addrs  = '{32'h42, 32'h40, 32'h200, 32'h240};
        writes = '{1'b1, 1'b0, 1'b0, 1'b0};
        respReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pushExp(writes[k], addrs[k], 32'h1234);
            sendReq(writes[k], addrs[k], 32'h1234, acc, ok);
            waitResp(rd, er, rc, ok);
            e = expQ.pop_front();
            nCompared++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                nMismatched++;
                $display("FAIL err_case_%h: got ok=%b rdata=%h err=%b, expected rdata=%h err=%b",
                         addrs[k], ok, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        int accCyc [3];
        int respCyc [3];
        int nAcc = 0;
        int nResp = 0;
        addrs = '{32'h40, 32'h10, 32'h44};
        respReady = 1'b1;
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = addrs[0];
        fork
            begin
                for (int t = 0; t < 60 && nAcc < 3; t++) begin
                    @(negedge clk);
                    if (reqReady) begin
                        accCyc[nAcc] = cycle;
                        pushExp(1'b0, reqAddr, '0);
                        @(posedge clk);
                        #1;
                        nAcc++;
                        if (nAcc < 3) reqAddr = addrs[nAcc];
                        else          reqValid = 1'b0;
                    end
                end
                reqValid = 1'b0;
            end
            begin
                expT e;
                for (int t = 0; t < 80 && nResp < 3; t++) begin
                    @(negedge clk);
                    if (respValid) begin
                        respCyc[nResp] = cycle;
                        nCompared++;
                        if (expQ.size() == 0) begin
                            nMismatched++;
                            $display("FAIL b2b_resp_%0d: got unexpected response rdata=%h, expected none", nResp, respRdata);
                        end else begin
                            e = expQ.pop_front();
                            if (respRdata !== e.rdata || respErr !== e.err) begin
                                nMismatched++;
                                $display("FAIL b2b_resp_%0d: got rdata=%h err=%b, expected rdata=%h err=%b",
                                         nResp, respRdata, respErr, e.rdata, e.err);
                            end
                        end
                        nResp++;
                    end
                end
            end
        join
        nCompared++;
        if (nAcc != 3 || nResp != 3) begin
            nMismatched++;
            $display("FAIL b2b_count: got %0d accepts %0d responses, expected 3 3", nAcc, nResp);
        end else begin
            for (int k = 0; k < 3; k++) begin
                nCompared++;
                if (respCyc[k] - accCyc[k] != int'(LATENCY)) begin
                    nMismatched++;
                    $display("FAIL b2b_latency_%0d: got %0d, expected %0d", k, respCyc[k] - accCyc[k], LATENCY);
                end
                if (k > 0) begin
                    nCompared++;
                    if (accCyc[k] - accCyc[k-1] != int'(LATENCY) + 1) begin
                        nMismatched++;
                        $display("FAIL b2b_spacing_%0d: got %0d, expected %0d", k, accCyc[k] - accCyc[k-1], LATENCY + 1);
                    end
                end
            end
        end
    endtask

    initial begin
        foreach (model[i]) model[i] = '0;
        test_reset();
        test_store_load();
        test_backpressure();
        test_errors();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder; it is the memory-side end of the CPU load/store interface.
- Accepts one word request at a time over a valid/ready handshake.
- Models fixed access latency, then returns a response (read data or write ack) over a second valid/ready handshake.
- Replaces the single-cycle data memory when the pipeline moves to stall-capable memory access.

Parameters:
- DEPTH, 128, number of 32-bit words stored (power of two, ≥2)
- LATENCY, 2, cycles from request accept to response valid (1..15)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept a request
- req_write_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data
- resp_valid_o  out  1  response present
- resp_ready_i  in  1  requester consumes response
- resp_rdata_o  out  32  load data; 0 for stores and errors
- resp_err_o  out  1  request was misaligned or out of range
- busy_o  out  1  a request is in flight (state ≠ IDLE)

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, counter=0
  - req_ready_o=1 after reset release; held 0 while rst_i=0
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, busy_o=0
  - all memory words cleared to 0
  - a request or response in flight is discarded
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1
  - On req_valid_i=1 at a rising edge, capture write/addr/wdata.
  - Go to WAIT with counter=LATENCY-1, or directly to RESP if LATENCY=1.
- WAIT:
  - req_ready_o=0
  - counter decrements each cycle; at the edge where counter==1, go to RESP.
- Entering RESP (a single edge):
  - Store: memory[addr[log2(DEPTH)+1:2]] written with wdata; rdata=0.
  - Load: rdata = that word.
  - Error: no memory access, rdata=0, err=1.
- Latency: a request accepted at edge N has resp_valid_o=1 from edge N+LATENCY.
- RESP:
  - resp_valid_o=1; resp_rdata_o and resp_err_o stable until consumed.
  - On resp_ready_i=1 at an edge, go to IDLE; resp_valid_o=0 and req_ready_o=1 from that edge.
  - No same-edge accept of a new request; minimum request-to-request spacing is LATENCY+1 cycles.
  - If resp_ready_i=1 is already held high, RESP lasts exactly one cycle.
- Error condition: addr[1:0]≠0, or addr[31:2] ≥ DEPTH.
- Inputs are ignored outside an IDLE accept edge; req_* may change freely while busy.
- Load after store to the same word returns the stored value (the store completes before its response).
- resp_rdata_o and resp_err_o are registered outputs; there is no combinational path from req_* to any output.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN
- Defined: error detection as above; an erroring request never modifies memory.
- Undefined:
  - resp_err_o tied 0
  - addr[1:0] ignored
  - word index = addr[log2(DEPTH)+1:2], so out-of-range addresses wrap modulo DEPTH and access memory normally

Test Plan (DEPTH=128, LATENCY=2, DMEM_ERR_CHECK_EN defined unless noted):
- Reset mid-WAIT: accept store to 0x10, drop rst_i the next cycle.
  - busy_o=0 and resp_valid_o=0 immediately.
  - After release, load 0x10 returns 0.
- Store 0x0000_0040 ← 0xDEADBEEF accepted at edge N, resp_ready_i held 1.
  - resp_valid_o=1 for exactly edge N+2..N+3, resp_rdata_o=0, resp_err_o=0.
  - Subsequent load 0x40 returns 0xDEADBEEF.
- Load 0x40 with resp_ready_i=0 for 5 cycles.
  - resp_valid_o stays 1 with rdata 0xDEADBEEF and req_ready_o stays 0.
  - Raising resp_ready_i returns to IDLE the next edge.
- Misaligned store 0x42 ← 0x1234.
  - resp_err_o=1, rdata=0.
  - Load 0x40 still returns 0xDEADBEEF.
- Out-of-range load 0x200: resp_err_o=1, rdata=0.
  - With macro undefined, load 0x240 returns the contents of 0x40 (0xDEADBEEF), err=0.
- Back-to-back: req_valid_i held 1 with three loads, resp_ready_i=1.
  - Accepts occur exactly 3 cycles apart.
  - Each response appears 2 cycles after its accept.
